bf_host_driver: RTL and testbench
=================================

Name: bf_host_driver

Overview:
- Host-side counterpart of the Brainfuck processor's byte channels.
- Drives the processor's in_data/in_valid/in_ack channel to download program text, append the terminating NUL and pulse start.
- During execution, serves program input bytes from an input FIFO and collects processor output bytes into an output FIFO.
- Sits between the system host (stream ports) and the processor toplevel.

Parameters:
DEPTH, 16, entries in each of the input and output FIFOs (power of 2, ≥2)
MAXPROG, 255, maximum program bytes accepted before forced termination (terminator occupies address MAXPROG)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
go  in  1  begin a load+run session
ld_data  in  8  program byte from host
ld_valid  in  1  program byte valid
ld_last  in  1  marks final program byte
ld_ready  out  1  program byte accepted
hin_data  in  8  runtime input byte from host
hin_valid  in  1  runtime input valid
hin_ready  out  1  input FIFO not full
hout_data  out  8  output FIFO head
hout_valid  out  1  output FIFO non-empty
hout_ready  in  1  host pops output
p_in_data  out  8  to processor in_data
p_in_valid  out  1  to processor in_valid
p_in_ack  in  1  from processor in_ack
p_out_data  in  8  from processor out_data
p_out_valid  in  1  from processor out_valid
p_out_ack  out  1  to processor out_ack
p_start  out  1  to processor start
p_ready  in  1  from processor ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
err_len  out  1  sticky: program truncated at MAXPROG, cleared on go
out_cnt  out  16  bytes produced in current/last run, cleared on go, saturating

Behaviour:
- Transfers occur on valid&&ack/ready in the same cycle. p_in_ack and ld_ready may be combinational, since processor in_ack depends on in_valid.
- Reset: state IDLE; FIFOs empty; p_in_valid=0, p_out_ack=0, p_start=0, ld_ready=0, done=0, err_len=0, out_cnt=0, busy=0, hout_valid=0, hin_ready=1.
- States: IDLE, LOAD, TERM, START, RUN, DONE.
- IDLE
  - p_in_valid=0.
  - go && p_ready → LOAD; clear prog_cnt, err_len, out_cnt.
  - go while !p_ready is ignored.
- LOAD
  - Passthrough: p_in_data=ld_data, p_in_valid=ld_valid, ld_ready=p_in_ack.
  - On transfer: prog_cnt+1.
  - If ld_last, or prog_cnt==MAXPROG-1 at the transfer → TERM.
  - Cap without ld_last sets err_len. ld_ready is 0 in every other state.
- TERM: p_in_valid=1, p_in_data=0x00; on p_in_ack → START.
- START: p_start=1 for exactly one cycle, p_in_valid=0 → RUN.
- RUN
  - p_in_valid = input FIFO non-empty && !p_ready; p_in_data = FIFO head; pop on p_in_valid&&p_in_ack.
  - The !p_ready guard is mandatory: processor in READY would otherwise overwrite program text.
  - p_out_ack = output FIFO not full; push p_out_data on p_out_valid&&p_out_ack; out_cnt+1 per push.
  - p_ready==1 → DONE.
- DONE: done=1 one cycle → IDLE.
- Input FIFO
  - Accepts hin_data in every state when not full; contents persist across runs.
  - Simultaneous push/pop when full: push refused (hin_ready=0). When empty: no pop.
- Output FIFO
  - Host pops in every state.
  - Simultaneous push and pop at full: p_out_ack still 0 (full computed from registered count); processor stalls in WRITE.
- Pointers wrap modulo DEPTH. Occupancy counters are 0..DEPTH wide.
- Empty program (ld_last on a NUL byte or immediate termination) is legal; run ends after processor clears memory.
- rst mid-operation returns everything to reset values immediately. The processor must be reset together with the driver.

Test Plan:
1. Program ",+." with ld_last on '.', hin 0x41 → 4 text writes (',','+','.',0x00), p_start one cycle, hout 0x42, out_cnt=1, done pulse, busy falls.
2. DEPTH=2, program "+.+.+." with hout_ready=0 → 2 entries buffered, p_out_ack=0, processor stalls; raise hout_ready → hout 0x01,0x02,0x03, done.
3. Program ",." with no hin for 50 cycles → p_in_valid=0, no done; push 0x07 → hout 0x07, done.
4. Push 0x55 after first run ends (IDLE, p_ready=1) → p_in_valid stays 0, text unchanged; second run ",." consumes 0x55 → hout 0x55.
5. 300 '+' bytes without ld_last → exactly 255 accepted, ld_ready drops, err_len=1, NUL written at address 255, run completes.
6. Assert rst during RUN with both FIFOs partially full → next cycle all outputs at reset values, FIFOs empty, state IDLE.

Source files
------------

// File: rtl/bf_host_driver_if.sv
// Bundle of every non-clock signal between bf_host_driver and its environment.
//   slave  : the driver's view (host load/stream ports, processor byte channels,
//            status outputs).
//   master : the environment's view (host plus processor), all directions flipped.
interface bf_host_driver_if;
  logic        go;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  hin_data;
  logic        hin_valid;
  logic        hin_ready;
  logic [7:0]  hout_data;
  logic        hout_valid;
  logic        hout_ready;
  logic [7:0]  p_in_data;
  logic        p_in_valid;
  logic        p_in_ack;
  logic [7:0]  p_out_data;
  logic        p_out_valid;
  logic        p_out_ack;
  logic        p_start;
  logic        p_ready;
  logic        busy;
  logic        done;
  logic        err_len;
  logic [15:0] out_cnt;

  modport slave (
    input  go, ld_data, ld_valid, ld_last,
    output ld_ready,
    input  hin_data, hin_valid,
    output hin_ready,
    output hout_data, hout_valid,
    input  hout_ready,
    output p_in_data, p_in_valid,
    input  p_in_ack,
    input  p_out_data, p_out_valid,
    output p_out_ack,
    output p_start,
    input  p_ready,
    output busy, done, err_len, out_cnt
  );

  modport master (
    output go, ld_data, ld_valid, ld_last,
    input  ld_ready,
    output hin_data, hin_valid,
    input  hin_ready,
    input  hout_data, hout_valid,
    output hout_ready,
    input  p_in_data, p_in_valid,
    output p_in_ack,
    output p_out_data, p_out_valid,
    input  p_out_ack,
    input  p_start,
    output p_ready,
    input  busy, done, err_len, out_cnt
  );
endinterface

// File: rtl/bf_host_driver.sv
// Host-side driver for the Brainfuck processor byte channels.
// A session (go) downloads program text from the ld_* stream into the
// processor, appends the terminating NUL, pulses p_start, then serves runtime
// input bytes from an input FIFO (hin_*) and collects output bytes into an
// output FIFO (hout_*) until the processor returns to ready.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bf_host_driver_if.slave -- go, ld_*, hin_*, hout_*, p_* channels,
//              busy, done (one-cycle), err_len (sticky truncation), out_cnt.
// Parameters: DEPTH (FIFO entries, power of 2, >=2), MAXPROG (max program bytes).
module bf_host_driver #(
  parameter int DEPTH   = 16,
  parameter int MAXPROG = 255
) (
  input logic             clk,
  input logic             rst,
  bf_host_driver_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(MAXPROG + 1);

  typedef enum logic [2:0] {IDLE, LOAD, TERM, START, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] prog_cnt;
  logic          start_r;
  logic          done_r;
  logic          busy_r;
  logic          err_r;
  logic [15:0]   out_cnt_r;

  logic [7:0]    in_mem [DEPTH];
  logic [AW-1:0] in_wr;
  logic [AW-1:0] in_rd;
  logic [CW-1:0] in_cnt;
  logic          in_push;
  logic          in_pop;
  logic          in_empty;
  logic          in_full;

  logic [7:0]    out_mem [DEPTH];
  logic [AW-1:0] out_wr;
  logic [AW-1:0] out_rd;
  logic [CW-1:0] out_cnt_fifo;
  logic          out_push;
  logic          out_pop;
  logic          out_empty;
  logic          out_full;
  logic          out_ack;

  logic [7:0]    p_in_data;
  logic          p_in_valid;
  logic          ld_ready;

  assign in_empty  = (in_cnt == '0);
  assign in_full   = (in_cnt == CW'(DEPTH));
  assign out_empty = (out_cnt_fifo == '0);
  assign out_full  = (out_cnt_fifo == CW'(DEPTH));

  // Processor-facing input channel: program passthrough in LOAD, NUL in TERM,
  // FIFO head in RUN. The !p_ready guard keeps runtime bytes from landing in
  // program memory once the processor has gone back to its load mode.
  always_comb begin
    p_in_valid = 1'b0;
    p_in_data  = 8'h00;
    ld_ready   = 1'b0;
    case (state)
      LOAD: begin
        p_in_valid = bus.ld_valid;
        p_in_data  = bus.ld_data;
        ld_ready   = bus.p_in_ack;
      end
      TERM: p_in_valid = 1'b1;
      RUN: begin
        p_in_valid = !in_empty && !bus.p_ready;
        p_in_data  = in_mem[in_rd];
      end
      default: ;
    endcase
  end

  // Full is taken from the registered count, so a host pop in the same cycle
  // does not open a slot for the processor; it simply retries next cycle.
  assign out_ack  = (state == RUN) && !out_full;
  assign in_push  = bus.hin_valid && !in_full;
  assign in_pop   = (state == RUN) && p_in_valid && bus.p_in_ack;
  assign out_push = bus.p_out_valid && out_ack;
  assign out_pop  = bus.hout_ready && !out_empty;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= bus.hin_data;
    if (out_push) out_mem[out_wr] <= bus.p_out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr        <= '0;
      in_rd        <= '0;
      in_cnt       <= '0;
      out_wr       <= '0;
      out_rd       <= '0;
      out_cnt_fifo <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + AW'(1);
      if (in_pop) in_rd <= in_rd + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + CW'(1);
        2'b01:   in_cnt <= in_cnt - CW'(1);
        default: ;
      endcase
      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop) out_rd <= out_rd + AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt_fifo <= out_cnt_fifo + CW'(1);
        2'b01:   out_cnt_fifo <= out_cnt_fifo - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prog_cnt  <= '0;
      start_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      out_cnt_r <= '0;
    end else begin
      start_r <= 1'b0;
      done_r  <= 1'b0;
      if (out_push && out_cnt_r != 16'hFFFF) out_cnt_r <= out_cnt_r + 16'd1;
      case (state)
        IDLE: begin
          if (bus.go && bus.p_ready) begin
            state     <= LOAD;
            busy_r    <= 1'b1;
            prog_cnt  <= '0;
            err_r     <= 1'b0;
            out_cnt_r <= '0;
          end
        end
        LOAD: begin
          if (bus.ld_valid && bus.p_in_ack) begin
            prog_cnt <= prog_cnt + PW'(1);
            if (bus.ld_last) begin
              state <= TERM;
            end else if (prog_cnt == PW'(MAXPROG - 1)) begin
              // Truncation: the NUL goes to address MAXPROG.
              state <= TERM;
              err_r <= 1'b1;
            end
          end
        end
        TERM: begin
          if (bus.p_in_ack) begin
            state   <= START;
            start_r <= 1'b1;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (bus.p_ready) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready   = ld_ready;
  assign bus.hin_ready  = !in_full;
  assign bus.hout_data  = out_mem[out_rd];
  assign bus.hout_valid = !out_empty;
  assign bus.p_in_data  = p_in_data;
  assign bus.p_in_valid = p_in_valid;
  assign bus.p_out_ack  = out_ack;
  assign bus.p_start    = start_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err_len    = err_r;
  assign bus.out_cnt    = out_cnt_r;
endmodule

// File: tb/tb_bf_host_driver.sv
// Bench for bf_host_driver with a small behavioural Brainfuck processor
// (+ - > < , . and NUL terminator) attached to the processor channels.
module tb_bf_host_driver;
  localparam int DEPTH   = 2;
  localparam int MAXPROG = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bf_host_driver_if bus();
  bf_host_driver #(.DEPTH(DEPTH), .MAXPROG(MAXPROG)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  // Processor model: ready = loading text; running = executing from address 0.
  logic [7:0] pmem [256];
  logic [7:0] dmem [16];
  logic [8:0] la;
  logic [7:0] pc;
  logic [3:0] dp;
  logic       prun;
  logic [7:0] instr;

  assign instr           = pmem[pc];
  assign bus.p_ready     = !prun;
  assign bus.p_in_ack    = !prun || (instr == 8'h2C);
  assign bus.p_out_valid = prun && (instr == 8'h2E);
  assign bus.p_out_data  = dmem[dp];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prun <= 1'b0; la <= '0; pc <= '0; dp <= '0;
    end else if (!prun) begin
      if (bus.p_in_valid) begin
        if (la < 9'd256) pmem[la[7:0]] <= bus.p_in_data;
        la <= la + 9'd1;
      end
      if (bus.p_start) begin
        prun <= 1'b1; pc <= '0; dp <= '0;
        for (int i = 0; i < 16; i++) dmem[i] <= 8'h00;
      end
    end else begin
      case (instr)
        8'h00: begin prun <= 1'b0; la <= '0; end
        8'h2B: begin dmem[dp] <= dmem[dp] + 8'd1; pc <= pc + 8'd1; end
        8'h2D: begin dmem[dp] <= dmem[dp] - 8'd1; pc <= pc + 8'd1; end
        8'h3E: begin dp <= dp + 4'd1; pc <= pc + 8'd1; end
        8'h3C: begin dp <= dp - 4'd1; pc <= pc + 8'd1; end
        8'h2C: if (bus.p_in_valid) begin dmem[dp] <= bus.p_in_data; pc <= pc + 8'd1; end
        8'h2E: if (bus.p_out_ack) pc <= pc + 8'd1;
        default: pc <= pc + 8'd1;
      endcase
    end
  end

  // Monitor: observed transfers, sampled mid-cycle.
  logic [7:0] exp_out[$], obs_out[$], exp_txt[$], obs_txt[$];
  int start_cycles = 0;
  int done_cycles  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.hout_valid && bus.hout_ready) obs_out.push_back(bus.hout_data);
      if (!prun && bus.p_in_valid && bus.p_in_ack) obs_txt.push_back(bus.p_in_data);
      if (bus.p_start) start_cycles++;
      if (bus.done) done_cycles++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_go();
    bus.go = 1'b1; tick(); bus.go = 1'b0;
  endtask

  task automatic push_hin(input logic [7:0] b);
    bit got = 0;
    bus.hin_data = b; bus.hin_valid = 1'b1;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk); got = bus.hin_ready; tick();
    end
    bus.hin_valid = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] prog[$], input bit last, output int acc);
    acc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      bit got = 0;
      bus.ld_data = prog[i]; bus.ld_valid = 1'b1;
      bus.ld_last = last && (i == prog.size() - 1);
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk); got = bus.ld_ready; tick();
      end
      if (!got) break;
      acc++;
    end
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(); ok = (done_cycles > 0);
    end
  endtask

  task automatic test_reset();
    logic [8:0] v;
    repeat (3) tick();
    v = {bus.busy, bus.done, bus.p_start, bus.p_in_valid, bus.p_out_ack,
         bus.ld_ready, bus.err_len, bus.hout_valid, bus.hin_ready};
    n_checks++;
    if (v !== 9'b000000001) $display("FAIL reset_ctrl: got %b want 000000001", v); else n_pass++;
    n_checks++;
    if (bus.out_cnt !== 16'd0) $display("FAIL reset_out_cnt: got %0d want 0", bus.out_cnt); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] prog[$]; logic [7:0] e, o; int acc; bit ok;
    prog = {8'h2C, 8'h2B, 8'h2E};
    obs_out.delete(); obs_txt.delete(); start_cycles = 0; done_cycles = 0;
    exp_txt = prog; exp_txt.push_back(8'h00);
    exp_out.push_back(8'h42);
    bus.hout_ready = 1'b1;
    push_hin(8'h41);
    pulse_go();
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", bus.busy); else n_pass++;
    load_prog(prog, 1'b1, acc);
    wait_done(200, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok) $display("FAIL basic_done: done not seen, want pulse"); else n_pass++;
    while (exp_txt.size() > 0) begin
      e = exp_txt.pop_front(); n_checks++;
      if (obs_txt.size() == 0) $display("FAIL basic_text: got none want %02h", e);
      else begin o = obs_txt.pop_front();
        if (o !== e) $display("FAIL basic_text: got %02h want %02h", o, e); else n_pass++; end
    end
    while (exp_out.size() > 0) begin
      e = exp_out.pop_front(); n_checks++;
      if (obs_out.size() == 0) $display("FAIL basic_out: got none want %02h", e);
      else begin o = obs_out.pop_front();
        if (o !== e) $display("FAIL basic_out: got %02h want %02h", o, e); else n_pass++; end
    end
    n_checks++;
    if (start_cycles != 1) $display("FAIL basic_start_len: got %0d want 1", start_cycles); else n_pass++;
    n_checks++;
    if (done_cycles != 1) $display("FAIL basic_done_len: got %0d want 1", done_cycles); else n_pass++;
    n_checks++;
    if (bus.out_cnt !== 16'd1) $display("FAIL basic_out_cnt: got %0d want 1", bus.out_cnt); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", bus.busy); else n_pass++;
    n_checks++;
    if (bus.err_len !== 1'b0) $display("FAIL basic_err_len: got %b want 0", bus.err_len); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] prog[$]; logic [7:0] e, o; int acc; bit ok;
    prog = {8'h2B, 8'h2E, 8'h2B, 8'h2E, 8'h2B, 8'h2E};
    obs_out.delete(); done_cycles = 0;
    exp_out = {8'h01, 8'h02, 8'h03};
    bus.hout_ready = 1'b0;
    pulse_go();
    load_prog(prog, 1'b1, acc);
    repeat (30) tick();
    n_checks++;
    if (done_cycles != 0) $display("FAIL bp_no_done: got %0d pulses want 0", done_cycles); else n_pass++;
    n_checks++;
    if ({bus.p_out_ack, bus.p_out_valid} !== 2'b01)
      $display("FAIL bp_stall: got ack/valid %b want 01", {bus.p_out_ack, bus.p_out_valid}); else n_pass++;
    n_checks++;
    if ({bus.hout_valid, bus.hout_data} !== {1'b1, 8'h01})
      $display("FAIL bp_head: got %b/%02h want 1/01", bus.hout_valid, bus.hout_data); else n_pass++;
    n_checks++;
    if (bus.out_cnt !== 16'd2) $display("FAIL bp_out_cnt_stall: got %0d want 2", bus.out_cnt); else n_pass++;
    bus.hout_ready = 1'b1;
    wait_done(100, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok) $display("FAIL bp_done: done not seen, want pulse"); else n_pass++;
    while (exp_out.size() > 0) begin
      e = exp_out.pop_front(); n_checks++;
      if (obs_out.size() == 0) $display("FAIL bp_out: got none want %02h", e);
      else begin o = obs_out.pop_front();
        if (o !== e) $display("FAIL bp_out: got %02h want %02h", o, e); else n_pass++; end
    end
    n_checks++;
    if (bus.out_cnt !== 16'd3) $display("FAIL bp_out_cnt: got %0d want 3", bus.out_cnt); else n_pass++;
  endtask

  task automatic test_starve();
    logic [7:0] prog[$]; logic [7:0] e, o; int acc; bit ok; int seen = 0;
    prog = {8'h2C, 8'h2E};
    obs_out.delete(); done_cycles = 0;
    pulse_go();
    load_prog(prog, 1'b1, acc);
    repeat (50) begin tick(); if (bus.p_in_valid) seen++; end
    n_checks++;
    if (seen != 0) $display("FAIL starve_in_valid: got %0d cycles want 0", seen); else n_pass++;
    n_checks++;
    if (done_cycles != 0) $display("FAIL starve_no_done: got %0d want 0", done_cycles); else n_pass++;
    push_hin(8'h07);
    exp_out.push_back(8'h07);
    wait_done(100, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok) $display("FAIL starve_done: done not seen, want pulse"); else n_pass++;
    while (exp_out.size() > 0) begin
      e = exp_out.pop_front(); n_checks++;
      if (obs_out.size() == 0) $display("FAIL starve_out: got none want %02h", e);
      else begin o = obs_out.pop_front();
        if (o !== e) $display("FAIL starve_out: got %02h want %02h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_idle_input();
    logic [7:0] prog[$]; logic [7:0] e, o; int acc; bit ok; int seen = 0;
    prog = {8'h2C, 8'h2E};
    obs_out.delete(); obs_txt.delete(); done_cycles = 0;
    push_hin(8'h55);
    repeat (10) begin tick(); if (bus.p_in_valid) seen++; end
    n_checks++;
    if (seen != 0) $display("FAIL idle_in_valid: got %0d cycles want 0", seen); else n_pass++;
    n_checks++;
    if (obs_txt.size() != 0 || la !== 9'd0) $display("FAIL idle_text_writes: got %0d/%0d want 0/0", obs_txt.size(), la); else n_pass++;
    n_checks++;
    if ({pmem[0], pmem[1]} !== {8'h2C, 8'h2E})
      $display("FAIL idle_text_kept: got %02h%02h want 2c2e", pmem[0], pmem[1]); else n_pass++;
    exp_out.push_back(8'h55);
    pulse_go();
    load_prog(prog, 1'b1, acc);
    wait_done(100, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok) $display("FAIL idle_done: done not seen, want pulse"); else n_pass++;
    while (exp_out.size() > 0) begin
      e = exp_out.pop_front(); n_checks++;
      if (obs_out.size() == 0) $display("FAIL idle_out: got none want %02h", e);
      else begin o = obs_out.pop_front();
        if (o !== e) $display("FAIL idle_out: got %02h want %02h", o, e); else n_pass++; end
    end
  endtask

  task automatic test_maxprog();
    logic [7:0] prog[$]; logic [7:0] e, o; int acc; bit ok;
    for (int i = 0; i < 300; i++) prog.push_back(8'h2B);
    obs_out.delete(); obs_txt.delete(); done_cycles = 0;
    for (int i = 0; i < MAXPROG; i++) exp_txt.push_back(8'h2B);
    exp_txt.push_back(8'h00);
    pulse_go();
    load_prog(prog, 1'b0, acc);
    n_checks++;
    if (acc != MAXPROG) $display("FAIL max_accepted: got %0d want %0d", acc, MAXPROG); else n_pass++;
    n_checks++;
    if ({bus.ld_ready, bus.err_len} !== 2'b01)
      $display("FAIL max_flags: got ld_ready/err_len %b want 01", {bus.ld_ready, bus.err_len}); else n_pass++;
    n_checks++;
    if (pmem[255] !== 8'h00) $display("FAIL max_nul_addr: got %02h want 00", pmem[255]); else n_pass++;
    wait_done(600, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok) $display("FAIL max_done: done not seen, want pulse"); else n_pass++;
    while (exp_txt.size() > 0) begin
      e = exp_txt.pop_front(); n_checks++;
      if (obs_txt.size() == 0) $display("FAIL max_text: got none want %02h", e);
      else begin o = obs_txt.pop_front();
        if (o !== e) $display("FAIL max_text: got %02h want %02h", o, e); else n_pass++; end
    end
    n_checks++;
    if (obs_out.size() != 0 || bus.out_cnt !== 16'd0)
      $display("FAIL max_no_out: got %0d/%0d want 0/0", obs_out.size(), bus.out_cnt); else n_pass++;
    n_checks++;
    if (bus.err_len !== 1'b1) $display("FAIL max_err_sticky: got %b want 1", bus.err_len); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] prog[$]; logic [7:0] e, o; int acc; bit ok; logic [8:0] v;
    prog = {8'h2B, 8'h2E, 8'h2E, 8'h2E};
    obs_out.delete(); done_cycles = 0;
    bus.hout_ready = 1'b0;
    pulse_go();
    n_checks++;
    if (bus.err_len !== 1'b0) $display("FAIL mid_err_clear: got %b want 0", bus.err_len); else n_pass++;
    load_prog(prog, 1'b1, acc);
    repeat (20) tick();
    push_hin(8'h99);
    push_hin(8'h98);
    n_checks++;
    if ({bus.busy, bus.hout_valid, bus.hin_ready, bus.out_cnt} !== {3'b110, 16'd2})
      $display("FAIL mid_prefill: got %b/%0d want 110/2", {bus.busy, bus.hout_valid, bus.hin_ready}, bus.out_cnt);
    else n_pass++;
    rst = 1'b1;
    #2;
    v = {bus.busy, bus.done, bus.p_start, bus.p_in_valid, bus.p_out_ack,
         bus.ld_ready, bus.err_len, bus.hout_valid, bus.hin_ready};
    n_checks++;
    if (v !== 9'b000000001) $display("FAIL mid_rst_ctrl: got %b want 000000001", v); else n_pass++;
    n_checks++;
    if (bus.out_cnt !== 16'd0) $display("FAIL mid_rst_out_cnt: got %0d want 0", bus.out_cnt); else n_pass++;
    tick();
    rst = 1'b0;
    bus.hout_ready = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (obs_out.size() != 0) $display("FAIL mid_out_fifo_empty: got %0d bytes want 0", obs_out.size()); else n_pass++;
    prog = {8'h2C, 8'h2E};
    exp_out.push_back(8'h33);
    pulse_go();
    load_prog(prog, 1'b1, acc);
    push_hin(8'h33);
    wait_done(100, ok);
    repeat (4) tick();
    n_checks++;
    if (!ok) $display("FAIL mid_after_done: done not seen, want pulse"); else n_pass++;
    while (exp_out.size() > 0) begin
      e = exp_out.pop_front(); n_checks++;
      if (obs_out.size() == 0) $display("FAIL mid_after_out: got none want %02h", e);
      else begin o = obs_out.pop_front();
        if (o !== e) $display("FAIL mid_after_out: got %02h want %02h", o, e); else n_pass++; end
    end
  endtask

  initial begin
    bus.go = 1'b0; bus.ld_data = 8'h00; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    bus.hin_data = 8'h00; bus.hin_valid = 1'b0; bus.hout_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_starve();
    test_idle_input();
    test_maxprog();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
